regread: RTL
============

Name: regread

Overview:
- Register-read stage directly downstream of the issue unit. Accepts up to iwd issued operations per cycle and reads their source operands from the physical register file.
- Merges in results completing in execution (bypass) and presents operand-complete bundles to the function units, holding them under back-pressure.
- Drops operations younger than a redirect.
- Drives the issue unit's per-lane issue signal.

Parameters:
- iwd, 2, issue/lane width (matches issue unit)
- prsz, 128, physical register count; address width pw = $clog2(prsz)
- opsz, 64, operation ID window size; opid low $clog2(opsz) bits are the ROB index
- xlen, 64, datapath width

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- red_bundle  input  red_bundle_t  redirect; valid when opid[15]; topid is oldest in-flight op
- iss_bundle  input  iss_bundle_t[iwd]  issued ops; lane valid when opid[15]
- issue  output  [iwd]  lane can accept this cycle (fed back to issue unit)
- rf_raddr  output  [iwd][2][pw]  register file read addresses; 1-cycle synchronous read
- rf_rvalue  input  [iwd][2][xlen]  read data, valid the cycle after the address
- exe_bundle  input  exe_bundle_t[iwd]  completing results; valid when opid[15]; prda is dest, res is value
- fu_accept  input  [iwd]  function unit takes rrd_bundle[i] this cycle
- rrd_bundle  output  rrd_bundle_t[iwd]  iss_bundle_t fields plus opa, opb [xlen]; added to types.sv

Behaviour:
- Lanes are independent. Each has a 2-bit FSM: EMPTY, READ, HELD.
- Reset: all lanes EMPTY; rrd_bundle = 0; issue = all ones; internal bypass latches cleared.
- issue[i] = (lane EMPTY) | (rrd valid & fu_accept[i]) | (lane entry flushed this cycle). A lane is never stalled by a flushed occupant.
- rf_raddr[i][k] = iss_bundle[i].prsa[k] (truncated to pw), driven combinationally every cycle.
- Capture: when issue[i] and iss_bundle[i].opid[15] and the op is not flushed by the current redirect, the bundle is latched and the lane goes to READ.
- Capture-cycle bypass: any valid exe_bundle[j] with prda == prsa[k] in the capture cycle is latched as a pending override. This covers the RF write-vs-read race.
- READ cycle: opX is selected in this priority order:
  - 0 if prsa == 0;
  - the current-cycle exe match (lowest j wins);
  - the capture-cycle latched override;
  - rf_rvalue.
- rrd_bundle[i] is valid in READ and HELD; latency from issue to rrd_bundle is exactly 1 cycle.
- READ and not accepted: the lane goes HELD, and the selected opa/opb are frozen into the lane.
- HELD: the frozen values are output. An exe match on a source whose prsb bit was set still updates that operand and clears the bit (store data arriving late).
- Accepted with no new capture: the lane goes EMPTY.
- Accepted with a same-cycle new capture: the lane goes READ (back-to-back, no bubble).
- prsb[1] set on a memory op (store data pending): opb is don't-care; prsb is passed through unchanged so the LSU re-handles it.
- Flush: an occupant is flushed when red_bundle.opid[15] & (occ.idx - topid) >= (red.idx - topid + 1), all mod opsz. Only strictly younger ops are flushed.
  - A flushed occupant's rrd_bundle is zeroed that same cycle, and the lane goes EMPTY at the next edge.
  - An incoming op matching the same condition is not captured.
- rst asserted mid-operation overrides everything: at the next edge all lanes are EMPTY and no bundle is output.

Optional Feature:
- REGREAD_PERF_EN defined adds outputs perf_stall [32] and perf_flush [32].
  - perf_stall: cycles any lane is HELD.
  - perf_flush: count of occupants or captures dropped by redirect.
  - Both are cleared on rst and saturate at all ones.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Single issue, no hazard: lane0 opid=0x8003, prsa={5,7}, RF[5]=0x11, RF[7]=0x22, fu_accept=1 -> next cycle rrd_bundle[0].opid=0x8003, opa=0x11, opb=0x22; lane EMPTY after.
- Bypass: capture prsa={9,0} while exe_bundle[1] writes prda=9 res=0xABCD (RF still stale) -> opa=0xABCD, opb=0.
- Back-pressure: fu_accept=0 for 3 cycles while the RF location changes -> issue[0]=0, operands stay at their first-read value, rrd_bundle held constant; accept in cycle 4 with a new op present -> new op appears cycle 5 with no bubble.
- Flush: topid=2, red opid=0x8004; lane0 holds idx 6, lane1 holds idx 3 -> lane0 output zeroed the same cycle and issue[0]=1; lane1 unaffected.
- Wrap-around: opsz=64, topid=62, red idx=63; held op idx=1 -> flushed; held op idx=62 -> retained.
- Store late data: HELD store with prsb[1]=1, exe writes its prsa[1] -> opb updated and prsb[1]=0 while held.

Source files
------------

// File: rtl/regread.sv
// regread: register-read stage between the issue unit and the function units, with operand bypass and redirect flush.
// Define REGREAD_PERF_EN to add the perf_stall / perf_flush saturating counters.
package regread_pkg;
    localparam int OPID_W = 16;
    localparam int PR_W   = 8;
    localparam int XLEN   = 64;

    typedef struct packed {
        logic [OPID_W-1:0] opid;
        logic [OPID_W-1:0] topid;
    } red_bundle_t;

    typedef struct packed {
        logic [OPID_W-1:0]     opid;
        logic [7:0]            op;
        logic                  is_mem;
        logic [PR_W-1:0]       prda;
        logic [1:0][PR_W-1:0]  prsa;
        logic [1:0]            prsb;
    } iss_bundle_t;

    typedef struct packed {
        logic [OPID_W-1:0] opid;
        logic [PR_W-1:0]   prda;
        logic [XLEN-1:0]   res;
    } exe_bundle_t;

    typedef struct packed {
        logic [OPID_W-1:0]     opid;
        logic [7:0]            op;
        logic                  is_mem;
        logic [PR_W-1:0]       prda;
        logic [1:0][PR_W-1:0]  prsa;
        logic [1:0]            prsb;
        logic [XLEN-1:0]       opa;
        logic [XLEN-1:0]       opb;
    } rrd_bundle_t;

    typedef enum logic [1:0] {
        LANE_EMPTY = 2'd0,
        LANE_READ  = 2'd1,
        LANE_HELD  = 2'd2
    } lane_state_e;
endpackage

module regread
    import regread_pkg::*;
#(
    parameter int iwd  = 2,
    parameter int prsz = 128,
    parameter int opsz = 64,
    parameter int xlen = 64
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  red_bundle_t                             red_bundle,
    input  iss_bundle_t [iwd-1:0]                   iss_bundle,
    output logic [iwd-1:0]                          issue,
    output logic [iwd-1:0][1:0][$clog2(prsz)-1:0]   rf_raddr,
    input  logic [iwd-1:0][1:0][xlen-1:0]           rf_rvalue,
    input  exe_bundle_t [iwd-1:0]                   exe_bundle,
    input  logic [iwd-1:0]                          fu_accept,
    output rrd_bundle_t [iwd-1:0]                   rrd_bundle
`ifdef REGREAD_PERF_EN
    ,
    output logic [31:0]                             perf_stall,
    output logic [31:0]                             perf_flush
`endif
);
    localparam int pw = $clog2(prsz);
    localparam int iw = $clog2(opsz);
    localparam logic [iw-1:0] idx_one = iw'(1);

    typedef struct packed {
        logic            hit;
        logic [XLEN-1:0] val;
    } byp_t;

    lane_state_e               state     [iwd];
    lane_state_e               state_nxt [iwd];
    iss_bundle_t               ent       [iwd];
    logic [1:0]                ovr_hit   [iwd];
    logic [1:0][XLEN-1:0]      ovr_val   [iwd];
    logic [1:0][XLEN-1:0]      held_val  [iwd];
    logic [1:0][XLEN-1:0]      sel_val   [iwd];
    byp_t                      cur_byp   [iwd][2];
    byp_t                      cap_byp   [iwd][2];
    logic [iwd-1:0]            occ_flush;
    logic [iwd-1:0]            lane_free;
    logic [iwd-1:0]            in_drop;
    logic [iwd-1:0]            capture;
    logic                      unused_bits;

    // Ages are distances from the oldest in-flight op, so ROB-index wrap-around falls out of the subtraction.
    function automatic logic is_younger(input logic [OPID_W-1:0] opid, input red_bundle_t red);
        logic [iw-1:0] occ_age;
        logic [iw-1:0] red_age;
        occ_age = opid[iw-1:0] - red.topid[iw-1:0];
        red_age = red.opid[iw-1:0] - red.topid[iw-1:0] + idx_one;
        return red.opid[OPID_W-1] && (occ_age >= red_age);
    endfunction

    // Scanned high-to-low so the lowest matching exe lane wins.
    function automatic byp_t exe_lookup(input logic [PR_W-1:0] src, input exe_bundle_t [iwd-1:0] exe);
        byp_t r;
        r = '0;
        for (int j = iwd - 1; j >= 0; j--) begin
            if (exe[j].opid[OPID_W-1] && exe[j].prda == src) begin
                r.hit = 1'b1;
                r.val = exe[j].res;
            end
        end
        return r;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so all lanes see pre-edge values.
    always_ff @(posedge clk) begin
        for (int i = 0; i < iwd; i++) begin
            if (rst) state[i] <= LANE_EMPTY;
            else     state[i] <= state_nxt[i];
        end
    end

    always_comb begin
        for (int i = 0; i < iwd; i++) begin
            // NOTE: every combinational output gets a default first so no path can infer a latch.
            state_nxt[i] = state[i];
            occ_flush[i] = (state[i] != LANE_EMPTY) && is_younger(ent[i].opid, red_bundle);
            lane_free[i] = (state[i] == LANE_EMPTY) || fu_accept[i] || occ_flush[i];
            in_drop[i]   = lane_free[i] && iss_bundle[i].opid[OPID_W-1]
                           && is_younger(iss_bundle[i].opid, red_bundle);
            capture[i]   = lane_free[i] && iss_bundle[i].opid[OPID_W-1] && !in_drop[i];
            if (capture[i])        state_nxt[i] = LANE_READ;
            else if (lane_free[i]) state_nxt[i] = LANE_EMPTY;
            else                   state_nxt[i] = LANE_HELD;
        end
    end

    always_comb begin
        for (int i = 0; i < iwd; i++) begin
            issue[i]      = lane_free[i];
            rrd_bundle[i] = '0;
            for (int k = 0; k < 2; k++) begin
                rf_raddr[i][k] = iss_bundle[i].prsa[k][pw-1:0];
                cap_byp[i][k]  = exe_lookup(iss_bundle[i].prsa[k], exe_bundle);
                cur_byp[i][k]  = exe_lookup(ent[i].prsa[k], exe_bundle);
                if (ent[i].prsa[k] == '0)  sel_val[i][k] = '0;
                else if (cur_byp[i][k].hit) sel_val[i][k] = cur_byp[i][k].val;
                else if (ovr_hit[i][k])     sel_val[i][k] = ovr_val[i][k];
                else                        sel_val[i][k] = rf_rvalue[i][k];
            end
            if (state[i] != LANE_EMPTY && !occ_flush[i]) begin
                rrd_bundle[i].opid   = ent[i].opid;
                rrd_bundle[i].op     = ent[i].op;
                rrd_bundle[i].is_mem = ent[i].is_mem;
                rrd_bundle[i].prda   = ent[i].prda;
                rrd_bundle[i].prsa   = ent[i].prsa;
                rrd_bundle[i].prsb   = ent[i].prsb;
                rrd_bundle[i].opa    = (state[i] == LANE_READ) ? sel_val[i][0] : held_val[i][0];
                rrd_bundle[i].opb    = (state[i] == LANE_READ) ? sel_val[i][1] : held_val[i][1];
            end
        end
    end

    // NOTE: payload registers are reset so the bypass latches start cleared; outputs are gated by lane state anyway.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < iwd; i++) begin
                ent[i]      <= '0;
                ovr_hit[i]  <= '0;
                ovr_val[i]  <= '0;
                held_val[i] <= '0;
            end
        end else begin
            for (int i = 0; i < iwd; i++) begin
                if (capture[i]) begin
                    ent[i] <= iss_bundle[i];
                    for (int k = 0; k < 2; k++) begin
                        ovr_hit[i][k] <= cap_byp[i][k].hit;
                        ovr_val[i][k] <= cap_byp[i][k].val;
                    end
                end else if (state[i] == LANE_READ) begin
                    held_val[i] <= sel_val[i];
                end else if (state[i] == LANE_HELD) begin
                    // Late store data: only sources still flagged pending pick up a completing result.
                    for (int k = 0; k < 2; k++) begin
                        if (ent[i].prsb[k] && ent[i].prsa[k] != '0 && cur_byp[i][k].hit) begin
                            held_val[i][k]   <= cur_byp[i][k].val;
                            ent[i].prsb[k]   <= 1'b0;
                        end
                    end
                end
            end
        end
    end

`ifdef REGREAD_PERF_EN
    logic        held_any;
    int          n_drop;
    logic [32:0] flush_sum;

    always_comb begin
        held_any = 1'b0;
        n_drop   = 0;
        for (int i = 0; i < iwd; i++) begin
            held_any = held_any | (state[i] == LANE_HELD);
            n_drop   = n_drop + int'(occ_flush[i]) + int'(in_drop[i]);
        end
        flush_sum = {1'b0, perf_flush} + 33'(n_drop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall <= '0;
            perf_flush <= '0;
        end else begin
            if (held_any && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
            perf_flush <= flush_sum[32] ? '1 : flush_sum[31:0];
        end
    end
`endif

    always_comb begin
        unused_bits = ^{red_bundle.opid[OPID_W-2:iw], red_bundle.topid[OPID_W-1:iw]};
        for (int j = 0; j < iwd; j++) unused_bits = unused_bits ^ (^exe_bundle[j].opid[OPID_W-2:0]);
    end
endmodule
